// File: rtl/motion_update_broadcaster.sv
`timescale 1ns/1ps
// motion_update_broadcaster
// Sweeps every cell of the X*Y*Z grid, reads each particle's position and
// velocity from the caches, applies pos += vel with periodic wrap per axis
// and broadcasts the new position, unchanged velocity and destination cell.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle pulse that begins a sweep (ignored while busy)
//   rd_cell_id/rd_address    cache read request {x,y,z} / address, qualified by rd_en
//   pos_in, vel_in           cache readout {z,y,x}, two cycles after the request
//   motion_update_enable     high from the first count read to the last broadcast
//   out_pos_data/out_vel_data/out_dst_cell/out_data_valid  broadcast word (zero when invalid)
//   busy, done               sweep in progress / one-cycle completion pulse
module motion_update_broadcaster #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4,
  parameter int CELL_NUM_X    = 3,
  parameter int CELL_NUM_Y    = 3,
  parameter int CELL_NUM_Z    = 3,
  parameter int PARTICLE_NUM  = 220
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [3*CELL_ID_WIDTH-1:0] rd_cell_id,
  output logic [ADDR_WIDTH-1:0]      rd_address,
  output logic                       rd_en,
  input  logic [3*DATA_WIDTH-1:0]    pos_in,
  input  logic [3*DATA_WIDTH-1:0]    vel_in,
  output logic                       motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]    out_pos_data,
  output logic [3*DATA_WIDTH-1:0]    out_vel_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_dst_cell,
  output logic                       out_data_valid,
  output logic                       busy,
  output logic                       done
);

  // state      | meaning
  // IDLE       | waiting for start
  // READ_COUNT | request address 0 (particle count) of the current cell
  // WAIT_COUNT | two cycles of cache latency, then latch the clamped count
  // STREAM     | request particle addresses 1..count back-to-back
  // DRAIN      | two cycles for the last reads to come back
  // NEXT_CELL  | advance z fastest, then y, then x
  // FINISH     | enable low, two cycles for the receiver, then done
  typedef enum logic [2:0] {
    IDLE, READ_COUNT, WAIT_COUNT, STREAM, DRAIN, NEXT_CELL, FINISH
  } state_t;

  localparam int FRAC_W = DATA_WIDTH - CELL_ID_WIDTH;
  localparam logic [CELL_ID_WIDTH-1:0] NUM_X   = CELL_ID_WIDTH'(CELL_NUM_X);
  localparam logic [CELL_ID_WIDTH-1:0] NUM_Y   = CELL_ID_WIDTH'(CELL_NUM_Y);
  localparam logic [CELL_ID_WIDTH-1:0] NUM_Z   = CELL_ID_WIDTH'(CELL_NUM_Z);
  localparam logic [CELL_ID_WIDTH-1:0] ONE_ID  = CELL_ID_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]    MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM);
  localparam logic [ADDR_WIDTH-1:0]    ONE_A   = ADDR_WIDTH'(1);

  state_t                     state_q, state_d;
  logic                       phase_q, phase_d;
  logic [CELL_ID_WIDTH-1:0]   cell_x_q, cell_x_d;
  logic [CELL_ID_WIDTH-1:0]   cell_y_q, cell_y_d;
  logic [CELL_ID_WIDTH-1:0]   cell_z_q, cell_z_d;
  logic [ADDR_WIDTH-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0]      rd_address_q, rd_address_d;
  logic                       rd_en_q, rd_en_d;
  logic                       pipe1_q, pipe1_d;
  logic                       pipe2_q, pipe2_d;
  logic                       enable_q, enable_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       out_valid_q, out_valid_d;
  logic [3*DATA_WIDTH-1:0]    out_pos_q, out_pos_d;
  logic [3*DATA_WIDTH-1:0]    out_vel_q, out_vel_d;
  logic [3*CELL_ID_WIDTH-1:0] out_dst_q, out_dst_d;

  logic [3*DATA_WIDTH-1:0]    new_pos;
  logic [3*CELL_ID_WIDTH-1:0] new_dst;
  logic [DATA_WIDTH-1:0]      wrapped;
  logic [ADDR_WIDTH-1:0]      raw_count, clamp_count;

  function automatic logic [CELL_ID_WIDTH-1:0] axis_cells(input int axis);
    case (axis)
      0:       return NUM_X;
      1:       return NUM_Y;
      default: return NUM_Z;
    endcase
  endfunction

  // Bit DATA_WIDTH of the extended sum acts as its sign; the span is one
  // full box length on this axis in fixed-point.
  function automatic logic [DATA_WIDTH-1:0] wrap_axis(
    input logic [DATA_WIDTH-1:0]    pos,
    input logic [DATA_WIDTH-1:0]    vel,
    input logic [CELL_ID_WIDTH-1:0] ncell
  );
    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] span;
    span = {1'b0, ncell, {FRAC_W{1'b0}}};
    sum  = {1'b0, pos} + {vel[DATA_WIDTH-1], vel};
    if (sum[DATA_WIDTH]) begin
      sum = sum + span;
    end else if (sum[DATA_WIDTH-1 -: CELL_ID_WIDTH] >= ncell) begin
      sum = sum - span;
    end
    return sum[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    new_pos = '0;
    new_dst = '0;
    wrapped = '0;
    for (int a = 0; a < 3; a++) begin
      wrapped = wrap_axis(pos_in[a*DATA_WIDTH +: DATA_WIDTH],
                          vel_in[a*DATA_WIDTH +: DATA_WIDTH], axis_cells(a));
      new_pos[a*DATA_WIDTH +: DATA_WIDTH] = wrapped;
      // positions are {z,y,x} but cell IDs are {x,y,z}
      new_dst[(2-a)*CELL_ID_WIDTH +: CELL_ID_WIDTH] =
        wrapped[DATA_WIDTH-1 -: CELL_ID_WIDTH] + ONE_ID;
    end
  end

  assign raw_count   = pos_in[ADDR_WIDTH-1:0];
  assign clamp_count = (raw_count > MAX_CNT) ? MAX_CNT : raw_count;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cell_x_d     = cell_x_q;
    cell_y_d     = cell_y_q;
    cell_z_d     = cell_z_q;
    count_d      = count_q;
    enable_d     = enable_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rd_en_d      = 1'b0;
    rd_address_d = '0;
    // a particle read is in flight for two cycles; its result is
    // registered on the third
    pipe1_d      = (state_q == STREAM);
    pipe2_d      = pipe1_q;
    out_valid_d  = pipe2_q;
    out_pos_d    = pipe2_q ? new_pos : '0;
    out_vel_d    = pipe2_q ? vel_in  : '0;
    out_dst_d    = pipe2_q ? new_dst : '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = READ_COUNT;
          cell_x_d = ONE_ID;
          cell_y_d = ONE_ID;
          cell_z_d = ONE_ID;
          busy_d   = 1'b1;
          enable_d = 1'b1;
          rd_en_d  = 1'b1;
        end
      end
      READ_COUNT: begin
        state_d = WAIT_COUNT;
        phase_d = 1'b0;
      end
      WAIT_COUNT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          count_d = clamp_count;
          if (clamp_count == '0) begin
            state_d = NEXT_CELL;
          end else begin
            state_d      = STREAM;
            rd_en_d      = 1'b1;
            rd_address_d = ONE_A;
          end
        end
      end
      STREAM: begin
        if (rd_address_q == count_q) begin
          state_d = DRAIN;
          phase_d = 1'b0;
        end else begin
          rd_en_d      = 1'b1;
          rd_address_d = rd_address_q + ONE_A;
        end
      end
      DRAIN: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = NEXT_CELL;
        end
      end
      NEXT_CELL: begin
        if (cell_z_q != NUM_Z) begin
          cell_z_d = cell_z_q + ONE_ID;
          state_d  = READ_COUNT;
          rd_en_d  = 1'b1;
        end else if (cell_y_q != NUM_Y) begin
          cell_z_d = ONE_ID;
          cell_y_d = cell_y_q + ONE_ID;
          state_d  = READ_COUNT;
          rd_en_d  = 1'b1;
        end else if (cell_x_q != NUM_X) begin
          cell_z_d = ONE_ID;
          cell_y_d = ONE_ID;
          cell_x_d = cell_x_q + ONE_ID;
          state_d  = READ_COUNT;
          rd_en_d  = 1'b1;
        end else begin
          // the last broadcast (if any) is visible this cycle
          state_d  = FINISH;
          enable_d = 1'b0;
          phase_d  = 1'b0;
        end
      end
      FINISH: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d  = 1'b0;
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cell_x_d = '0;
          cell_y_d = '0;
          cell_z_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      cell_x_q     <= '0;
      cell_y_q     <= '0;
      cell_z_q     <= '0;
      count_q      <= '0;
      rd_address_q <= '0;
      rd_en_q      <= 1'b0;
      pipe1_q      <= 1'b0;
      pipe2_q      <= 1'b0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pos_q    <= '0;
      out_vel_q    <= '0;
      out_dst_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cell_x_q     <= cell_x_d;
      cell_y_q     <= cell_y_d;
      cell_z_q     <= cell_z_d;
      count_q      <= count_d;
      rd_address_q <= rd_address_d;
      rd_en_q      <= rd_en_d;
      pipe1_q      <= pipe1_d;
      pipe2_q      <= pipe2_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      out_valid_q  <= out_valid_d;
      out_pos_q    <= out_pos_d;
      out_vel_q    <= out_vel_d;
      out_dst_q    <= out_dst_d;
    end
  end

  assign rd_cell_id           = {cell_x_q, cell_y_q, cell_z_q};
  assign rd_address           = rd_address_q;
  assign rd_en                = rd_en_q;
  assign motion_update_enable = enable_q;
  assign out_pos_data         = out_pos_q;
  assign out_vel_data         = out_vel_q;
  assign out_dst_cell         = out_dst_q;
  assign out_data_valid       = out_valid_q;
  assign busy                 = busy_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_motion_update_broadcaster.sv
`timescale 1ns/1ps
// Testbench for motion_update_broadcaster: a two-cycle cache model feeds the
// DUT from small per-cell tables; expected broadcasts are queued when a sweep
// is set up and a monitor pops and compares them as they appear.
module tb_motion_update_broadcaster;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] rd_cell_id;
  logic [7:0]  rd_address;
  logic        rd_en;
  logic [95:0] pos_in;
  logic [95:0] vel_in;
  logic        motion_update_enable;
  logic [95:0] out_pos_data;
  logic [95:0] out_vel_data;
  logic [11:0] out_dst_cell;
  logic        out_data_valid;
  logic        busy;
  logic        done;

  motion_update_broadcaster dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_cell_id(rd_cell_id), .rd_address(rd_address), .rd_en(rd_en),
    .pos_in(pos_in), .vel_in(vel_in),
    .motion_update_enable(motion_update_enable),
    .out_pos_data(out_pos_data), .out_vel_data(out_vel_data),
    .out_dst_cell(out_dst_cell), .out_data_valid(out_data_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] pos;
    logic [95:0] vel;
    logic [11:0] dst;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [95:0] pos_mem [27][8];
  logic [95:0] vel_mem [27][8];
  logic [7:0]  cnt_mem [27];

  // cache model: two-stage request pipeline
  logic        s1_en = 1'b0, s2_en = 1'b0;
  logic [7:0]  s1_addr = '0, s2_addr = '0;
  logic [11:0] s1_cell = '0, s2_cell = '0;
  int          ci;

  function automatic int cidx(int x, int y, int z);
    return (x - 1) * 9 + (y - 1) * 3 + (z - 1);
  endfunction

  function automatic int cidx_of(logic [11:0] c);
    int x, y, z;
    x = int'(c[11:8]);
    y = int'(c[7:4]);
    z = int'(c[3:0]);
    if (x < 1 || x > 3 || y < 1 || y > 3 || z < 1 || z > 3) return 0;
    return cidx(x, y, z);
  endfunction

  always @(posedge clk) begin
    s1_en   <= rd_en;
    s1_addr <= rd_address;
    s1_cell <= rd_cell_id;
    s2_en   <= s1_en;
    s2_addr <= s1_addr;
    s2_cell <= s1_cell;
  end

  always_comb begin
    ci     = 0;
    pos_in = {3{32'hA5A5_A5A5}};
    vel_in = {3{32'h5A5A_5A5A}};
    if (s2_en) begin
      ci = cidx_of(s2_cell);
      if (s2_addr == 8'd0) begin
        pos_in = {64'hDEAD_BEEF_0BAD_F00D, 24'hCAFE00, cnt_mem[ci]};
        vel_in = '1;
      end else if (s2_addr < 8'd8) begin
        pos_in = pos_mem[ci][s2_addr[2:0]];
        vel_in = vel_mem[ci][s2_addr[2:0]];
      end else begin
        pos_in = '0;
        vel_in = '0;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // per-sweep observations collected by the monitor
  int   done_cnt, en_low_cnt, en_fall, last_valid, done_cyc, cnt_reads, last_cnt_read;
  logic busy_at_done, saw_addr3;
  int   valid_cycles[$];
  int   addr_log[$];
  int   addr_cyc[$];

  task automatic clear_stats();
    done_cnt = 0; en_low_cnt = 0; en_fall = -1; last_valid = -1; done_cyc = -1;
    cnt_reads = 0; last_cnt_read = -1; busy_at_done = 1'b1; saw_addr3 = 1'b0;
    valid_cycles.delete(); addr_log.delete(); addr_cyc.delete();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_data_valid) begin
        valid_cycles.push_back(cyc);
        last_valid = cyc;
        check("en_with_valid", motion_update_enable, 1);
        check("bcast_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("bcast_pos", out_pos_data, e.pos);
          check("bcast_vel", out_vel_data, e.vel);
          check("bcast_dst", out_dst_cell, e.dst);
        end
      end else begin
        check("idle_outputs_zero", |{out_pos_data, out_vel_data, out_dst_cell}, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (busy && !motion_update_enable) begin
        en_low_cnt++;
        if (en_fall < 0) en_fall = cyc;
      end
      if (rd_en && rd_address == 8'd0) begin
        cnt_reads++;
        last_cnt_read = cyc;
      end
      if (rd_en && rd_address != 8'd0 && rd_cell_id == 12'h111) begin
        addr_log.push_back(int'(rd_address));
        addr_cyc.push_back(cyc);
        if (rd_address == 8'd3) saw_addr3 = 1'b1;
      end
    end
  end

  task automatic clear_mem();
    for (int c = 0; c < 27; c++) begin
      cnt_mem[c] = '0;
      for (int a = 0; a < 8; a++) begin
        pos_mem[c][a] = '0;
        vel_mem[c][a] = '0;
      end
    end
  endtask

  task automatic put(input int x, input int y, input int z, input int a,
                     input logic [95:0] p, input logic [95:0] v,
                     input logic [95:0] ep, input logic [11:0] ed);
    pos_mem[cidx(x, y, z)][a] = p;
    vel_mem[cidx(x, y, z)][a] = v;
    exp_q.push_back('{ep, v, ed});
  endtask

  // cell {1,1,1}: five particles, all moving +0x0010_0000 in x
  task automatic load_five();
    cnt_mem[cidx(1, 1, 1)] = 8'd5;
    put(1, 1, 1, 1, {32'h0, 32'h0, 32'h0100_0000}, {32'h0, 32'h0, 32'h0010_0000},
        {32'h0, 32'h0, 32'h0110_0000}, 12'h111);
    put(1, 1, 1, 2, {32'h0, 32'h0, 32'h0FF8_0000}, {32'h0, 32'h0, 32'h0010_0000},
        {32'h0, 32'h0, 32'h1008_0000}, 12'h211);
    put(1, 1, 1, 3, {32'h0, 32'h0, 32'h2FF8_0000}, {32'h0, 32'h0, 32'h0010_0000},
        {32'h0, 32'h0, 32'h0008_0000}, 12'h111);
    put(1, 1, 1, 4, {32'h0, 32'h0, 32'h2000_0000}, {32'h0, 32'h0, 32'h0010_0000},
        {32'h0, 32'h0, 32'h2010_0000}, 12'h311);
    put(1, 1, 1, 5, {32'h0, 32'h0, 32'h0000_0000}, {32'hFFFF_FFFF, 32'h0, 32'h0010_0000},
        {32'h2FFF_FFFF, 32'h0, 32'h0010_0000}, 12'h113);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {busy, done, motion_update_enable, rd_en, out_data_valid,
                 |rd_cell_id, |rd_address, |{out_pos_data, out_vel_data, out_dst_cell}}, 0);
  endtask

  // Called at negedge+1; start is sampled on the next rising edge.
  task automatic run_sweep(input int budget, input int glitch_a, input int glitch_b);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      start = (i == glitch_a || i == glitch_b);
      @(negedge clk); #1;
    end
    start = 1'b0;
    check("done_seen", done_cnt != 0, 1);
    repeat (10) begin
      @(negedge clk); #1;
    end
    check("one_done_per_start", done_cnt, 1);
    check("busy_low_at_done", busy_at_done, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    clear_stats();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk); #1;

    // sweep 1: plain move, wraps on x and y, negative move into last cell
    clear_mem();
    clear_stats();
    cnt_mem[cidx(1, 1, 1)] = 8'd1;
    put(1, 1, 1, 1, {32'h0, 32'h0, 32'h0800_0000}, {32'h0, 32'h0, 32'h1000_0000},
        {32'h0, 32'h0, 32'h1800_0000}, 12'h211);
    cnt_mem[cidx(2, 1, 3)] = 8'd1;
    put(2, 1, 3, 1, {32'h1234_5678, 32'h2F00_0000, 32'h0100_0000},
        {32'h0000_0000, 32'h0200_0000, 32'hFE00_0000},
        {32'h1234_5678, 32'h0100_0000, 32'h2F00_0000}, 12'h312);
    cnt_mem[cidx(3, 3, 3)] = 8'd1;
    put(3, 3, 3, 1, {32'h1FFF_FFFF, 32'h0000_0010, 32'h2800_0000},
        {32'h0000_0001, 32'hFFFF_FFF0, 32'hF800_0000},
        {32'h2000_0000, 32'h0000_0000, 32'h2000_0000}, 12'h313);
    run_sweep(1000, -1, -1);
    check("s1_valid_count", valid_cycles.size(), 3);
    check("s1_count_reads", cnt_reads, 27);
    check("s1_enable_fall_after_last", en_fall - last_valid, 1);
    check("s1_done_after_fall", done_cyc - en_fall, 2);
    check("s1_enable_low_cycles", en_low_cnt, 2);

    // sweep 2: five back-to-back particles, and a count clamped to 220
    clear_mem();
    clear_stats();
    load_five();
    cnt_mem[cidx(3, 3, 3)] = 8'hFF;
    for (int i = 0; i < 220; i++) exp_q.push_back('{96'h0, 96'h0, 12'h111});
    run_sweep(3000, -1, -1);
    check("s2_valid_count", valid_cycles.size(), 225);
    check("s2_addr_count", addr_log.size(), 5);
    if (addr_log.size() >= 5 && valid_cycles.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("s2_addr_order", addr_log[i], i + 1);
      for (int i = 1; i < 5; i++) check("s2_addr_b2b", addr_cyc[i] - addr_cyc[0], i);
      check("s2_first_latency", valid_cycles[0] - addr_cyc[0], 3);
      for (int i = 1; i < 5; i++) check("s2_valid_b2b", valid_cycles[i] - valid_cycles[0], i);
    end

    // sweep 3: all cells empty, stray start pulses while busy
    clear_mem();
    clear_stats();
    run_sweep(400, 10, 50);
    check("s3_valid_count", valid_cycles.size(), 0);
    check("s3_count_reads", cnt_reads, 27);
    check("s3_done_after_last_read", done_cyc - last_cnt_read, 6);
    check("s3_enable_low_cycles", en_low_cnt, 2);

    // sweep 4: reset during STREAM, then restart on the first cycle out of reset
    clear_mem();
    clear_stats();
    load_five();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && !saw_addr3; i++) begin
      @(negedge clk); #1;
    end
    check("s4_reached_stream", saw_addr3, 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check_all_zero("s4_reset_outputs");
    check("s4_no_done_on_reset", done_cnt, 0);
    exp_q.delete();
    clear_stats();
    load_five();
    rst = 1'b0;
    run_sweep(1000, -1, -1);
    check("s4_valid_count", valid_cycles.size(), 5);
    check("s4_count_reads", cnt_reads, 27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
